// File: rtl/fractional_baud_gen.sv
// Fractional baud/oversample tick generator: an NCO phase accumulator whose carry
// is the oversample tick, with a per-bit sample counter deriving mid-bit and baud ticks.
module fractional_baud_gen #(
    parameter int unsigned CLK_FREQ   = 32'd50000000,
    parameter int unsigned ACC_W      = 32'd24,
    parameter int unsigned OVERSAMPLE = 32'd16,
    parameter int unsigned RESET_INCR = 32'd51540
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_en,
    input  logic                          i_resync,
    input  logic                          i_load,
    input  logic [ACC_W-1:0]              i_incr,
    output logic                          o_os_tick,
    output logic                          o_mid_tick,
    output logic                          o_baud_tick,
    output logic [$clog2(OVERSAMPLE)-1:0] o_os_cnt
);

    localparam int unsigned       OS_W     = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0]   OS_LAST  = OS_W'(OVERSAMPLE - 32'd1);
    localparam logic [OS_W-1:0]   OS_MID   = OS_W'(OVERSAMPLE / 32'd2 - 32'd1);
    localparam logic [ACC_W-1:0]  INCR_RST = ACC_W'(RESET_INCR);

    // Reject configurations the accumulator and sample counter cannot represent.
    generate
        if (ACC_W < 32'd4 || ACC_W > 32'd32 || OVERSAMPLE < 32'd2 ||
            (OVERSAMPLE % 32'd2) != 32'd0 || CLK_FREQ == 32'd0) begin : g_bad_param
            $error("fractional_baud_gen: illegal parameter set");
        end
    endgenerate

    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] incr_r;
    logic [OS_W-1:0]  os_cnt_r;
    logic             os_tick_r;
    logic             mid_tick_r;
    logic             baud_tick_r;

    logic [ACC_W:0]   sum_s;
    logic             carry_s;
    logic [ACC_W-1:0] acc_nxt_s;
    logic [OS_W-1:0]  os_cnt_nxt_s;
    logic             os_tick_nxt_s;
    logic             mid_tick_nxt_s;
    logic             baud_tick_nxt_s;

    // Next-state: resync beats enable; the accumulator sum is one bit wider to expose the carry.
    always_comb begin
        sum_s           = {1'b0, acc_r} + {1'b0, incr_r};
        carry_s         = sum_s[ACC_W];
        acc_nxt_s       = acc_r;
        os_cnt_nxt_s    = os_cnt_r;
        os_tick_nxt_s   = 1'b0;
        mid_tick_nxt_s  = 1'b0;
        baud_tick_nxt_s = 1'b0;
        if (i_resync) begin
            acc_nxt_s    = {ACC_W{1'b0}};
            os_cnt_nxt_s = {OS_W{1'b0}};
        end else if (!i_en) begin
            acc_nxt_s    = acc_r;
            os_cnt_nxt_s = os_cnt_r;
        end else begin
            acc_nxt_s      = sum_s[ACC_W-1:0];
            os_tick_nxt_s  = carry_s;
            // Mid-bit decision uses the sample index before this carry advances it.
            mid_tick_nxt_s = carry_s && (os_cnt_r == OS_MID);
            if (carry_s && (os_cnt_r == OS_LAST)) begin
                os_cnt_nxt_s    = {OS_W{1'b0}};
                baud_tick_nxt_s = 1'b1;
            end else if (carry_s) begin
                os_cnt_nxt_s = os_cnt_r + OS_W'(1'b1);
            end else begin
                os_cnt_nxt_s = os_cnt_r;
            end
        end
    end

    // Phase, sample index and tick registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_r       <= {ACC_W{1'b0}};
            os_cnt_r    <= {OS_W{1'b0}};
            os_tick_r   <= 1'b0;
            mid_tick_r  <= 1'b0;
            baud_tick_r <= 1'b0;
        end else begin
            acc_r       <= acc_nxt_s;
            os_cnt_r    <= os_cnt_nxt_s;
            os_tick_r   <= os_tick_nxt_s;
            mid_tick_r  <= mid_tick_nxt_s;
            baud_tick_r <= baud_tick_nxt_s;
        end
    end

    // Increment register; loading leaves the phase untouched so rate changes are glitch-free.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            incr_r <= INCR_RST;
        end else if (i_load) begin
            incr_r <= i_incr;
        end else begin
            incr_r <= incr_r;
        end
    end

    assign o_os_tick   = os_tick_r;
    assign o_mid_tick  = mid_tick_r;
    assign o_baud_tick = baud_tick_r;
    assign o_os_cnt    = os_cnt_r;

endmodule

// File: tb/tb_fractional_baud_gen.sv
// Scoreboard bench for fractional_baud_gen (ACC_W=4, OVERSAMPLE=4, RESET_INCR=8):
// stimulus pushes per-edge expectations, a monitor pops and compares after each edge.
module tb_fractional_baud_gen;

    logic       clk = 1'b0;
    logic       i_rst_n;
    logic       i_en;
    logic       i_resync;
    logic       i_load;
    logic [3:0] i_incr;
    logic       o_os_tick;
    logic       o_mid_tick;
    logic       o_baud_tick;
    logic [1:0] o_os_cnt;

    typedef struct packed {
        logic       os;
        logic       mid;
        logic       baud;
        logic [1:0] cnt;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] m_acc;
    logic [3:0] m_incr;
    logic [1:0] m_cnt;

    fractional_baud_gen #(
        .ACC_W(4),
        .OVERSAMPLE(4),
        .RESET_INCR(8)
    ) dut (
        .i_clk(clk),
        .i_rst_n(i_rst_n),
        .i_en(i_en),
        .i_resync(i_resync),
        .i_load(i_load),
        .i_incr(i_incr),
        .o_os_tick(o_os_tick),
        .o_mid_tick(o_mid_tick),
        .o_baud_tick(o_baud_tick),
        .o_os_cnt(o_os_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // Monitor: compare the outputs produced by each edge with the queued expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({o_os_tick, o_mid_tick, o_baud_tick, o_os_cnt} !== e) begin
                errors++;
                $display("FAIL sb t=%0t got os=%b mid=%b baud=%b cnt=%0d want os=%b mid=%b baud=%b cnt=%0d",
                         $time, o_os_tick, o_mid_tick, o_baud_tick, o_os_cnt,
                         e.os, e.mid, e.baud, e.cnt);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    // One clock with reset held: expectation all zero, model back to reset state.
    task automatic rst_cycle();
        exp_t e;
        i_rst_n = 1'b0;
        m_acc   = 4'd0;
        m_cnt   = 2'd0;
        m_incr  = 4'd8;
        e       = '0;
        sb.push_back(e);
        @(negedge clk);
    endtask

    // Drive one edge's inputs, predict its outputs, then wait until they are visible.
    task automatic cyc(input logic en, input logic rs, input logic ld, input logic [3:0] inc);
        exp_t       e;
        logic [4:0] sum;
        i_en     = en;
        i_resync = rs;
        i_load   = ld;
        i_incr   = inc;
        e        = '0;
        if (rs) begin
            m_acc = 4'd0;
            m_cnt = 2'd0;
        end else if (en) begin
            sum    = {1'b0, m_acc} + {1'b0, m_incr};
            e.os   = sum[4];
            e.mid  = sum[4] && (m_cnt == 2'd1);
            e.baud = sum[4] && (m_cnt == 2'd3);
            if (sum[4]) m_cnt = m_cnt + 2'd1;
            m_acc = sum[3:0];
        end
        if (ld) m_incr = inc;
        e.cnt = m_cnt;
        sb.push_back(e);
        @(negedge clk);
    endtask

    // Incr=8 from phase 0: os every 2nd edge, mid on edge 4, baud on edge 8 of each 8.
    task automatic p1_pattern(input string tag);
        logic [4:0] want;
        for (int e = 1; e <= 16; e++) begin
            cyc(1'b1, 1'b0, 1'b0, 4'd0);
            want = {(e % 2) == 0, (e % 8) == 4, (e % 8) == 0, 2'((e / 2) % 4)};
            chk(tag, int'({o_os_tick, o_mid_tick, o_baud_tick, o_os_cnt}), int'(want));
        end
    endtask

    initial begin
        int ticks[$];
        int cnt;
        int first;
        int found;

        i_rst_n  = 1'b0;
        i_en     = 1'b0;
        i_resync = 1'b0;
        i_load   = 1'b0;
        i_incr   = 4'd0;
        repeat (3) rst_cycle();
        chk("reset_out", int'({o_os_tick, o_mid_tick, o_baud_tick, o_os_cnt}), 0);
        i_rst_n = 1'b1;
        p1_pattern("pattern_incr8");

        // Rate change to 3: the loading edge still adds 8 (acc 0 -> 8).
        cyc(1'b1, 1'b0, 1'b1, 4'd3);
        for (int i = 0; i < 48; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 4'd0);
            if (o_os_tick) ticks.push_back(i);
        end
        chk("incr3_count", ticks.size(), 9);
        for (int k = 0; k + 3 < ticks.size(); k++)
            chk("incr3_period", ticks[k + 3] - ticks[k], 16);

        // Back to 8, then advance to a mid-bit point with nonzero phase.
        cyc(1'b1, 1'b0, 1'b1, 4'd8);
        for (int i = 0; i < 20; i++) begin
            if (m_cnt == 2'd2 && m_acc != 4'd0) break;
            cyc(1'b1, 1'b0, 1'b0, 4'd0);
        end
        chk("pre_resync_cnt", int'(o_os_cnt), 2);
        cyc(1'b1, 1'b1, 1'b0, 4'd0);
        chk("resync_out", int'({o_os_tick, o_mid_tick, o_baud_tick, o_os_cnt}), 0);
        first = 0;
        for (int n = 1; n <= 16; n++) begin
            cyc(1'b1, 1'b0, 1'b0, 4'd0);
            if (o_baud_tick) begin
                first = n;
                break;
            end
        end
        chk("resync_to_baud", first, 8);

        // Freeze: phase 8 / cnt 1, then 5 disabled edges, then the carry lands on the first enabled edge.
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 4'd0);
        cnt = 0;
        repeat (5) begin
            cyc(1'b0, 1'b0, 1'b0, 4'd0);
            cnt += int'(o_os_tick) + int'(o_mid_tick) + int'(o_baud_tick);
        end
        chk("en_low_ticks", cnt, 0);
        chk("en_low_cnt", int'(o_os_cnt), 1);
        cyc(1'b1, 1'b0, 1'b0, 4'd0);
        chk("resume_tick", int'({o_os_tick, o_os_cnt}), 6);

        // Zero increment: silence; then 15: 15 carries per 16 edges.
        cyc(1'b1, 1'b0, 1'b1, 4'd0);
        cnt = 0;
        repeat (100) begin
            cyc(1'b1, 1'b0, 1'b0, 4'd0);
            cnt += int'(o_os_tick) + int'(o_mid_tick) + int'(o_baud_tick);
        end
        chk("incr0_ticks", cnt, 0);
        cyc(1'b1, 1'b0, 1'b1, 4'd15);
        cnt = 0;
        repeat (32) begin
            cyc(1'b1, 1'b0, 1'b0, 4'd0);
            cnt += int'(o_os_tick);
        end
        chk("incr15_ticks", cnt, 30);

        // Async reset while a baud tick is high must drop it with no clock edge.
        found = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 4'd0);
            if (o_baud_tick) begin
                found = 1;
                break;
            end
        end
        chk("baud_seen", found, 1);
        #2 i_rst_n = 1'b0;
        #1 chk("async_reset_out", int'({o_os_tick, o_mid_tick, o_baud_tick, o_os_cnt}), 0);
        repeat (2) rst_cycle();
        i_rst_n = 1'b1;
        p1_pattern("pattern_after_reset");

        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
